eeprom_param_loader: RTL
========================

Name: eeprom_param_loader

Overview:
- Command sequencer directly upstream of the I2C EEPROM controller; drives its dev-address, reg-address, write-data and control inputs; consumes its status word and four read-data bytes.
- On i_start, reads N_WORDS 32-bit words from the EEPROM and presents each on a valid-strobed output bus for the parameter register bank.
- Also accepts single-word write requests and enforces the EEPROM write-cycle wait before the next transaction.

Parameters:
- DEV_ADDR, 7'h50, EEPROM 7-bit device address.
- BASE_ADDR, 16'h0000, byte address of word 0.
- N_WORDS, 16, words per load, range 1..256.
- CLK_RATE, 3'd7, value driven on controller clk_rate field (7 = 390 kHz at 100 MHz).
- TIMEOUT_CYCLES, 200000, i_clk cycles allowed from enable to finish.
- WR_WAIT_CYCLES, 500000, post-write idle time (5 ms at 100 MHz).

Ports:
- i_clk  in  1  system clock, 100 MHz.
- i_rst_n  in  1  asynchronous active-low reset.
- i_start  in  1  one-cycle pulse: begin load.
- i_wr_req  in  1  one-cycle pulse: write one word.
- i_wr_addr  in  16  byte address for write.
- i_wr_data  in  32  write word, MSB sent first.
- o_busy  out  1  sequencer not in IDLE.
- o_done  out  1  one-cycle pulse at end of load or write.
- o_err  out  1  sticky timeout flag; cleared by next accepted i_start/i_wr_req.
- o_word  out  32  loaded word.
- o_word_idx  out  8  index of o_word.
- o_word_vld  out  1  one-cycle strobe, o_word/o_word_idx valid.
- o_dev_addr  out  7  to controller i_dev_addr.
- o_reg_addr  out  16  to controller i_reg_addr.
- o_w_data  out  32  to controller i_w_data.
- o_ctrl  out  32  to controller i_ctrl: [0] enable, [3:1] op_mode (0 write, 1 read), [6:4] CLK_RATE, rest 0.
- i_status  in  32  from controller o_status; only bit 1 (finish) is used.
- i_rd_data, i_rd_data_2, i_rd_data_3, i_rd_data_4  in  8 each  controller read bytes, first byte received = i_rd_data.

Behaviour:
- Reset (async, i_rst_n=0): state IDLE; all outputs 0 except o_dev_addr=DEV_ADDR and o_ctrl[6:4]=CLK_RATE; idx, timers 0; o_err 0.
- Finish synchronisation: i_status[1] comes from the slow SCL domain. It passes through a 2-FF synchroniser; rise/fall are detected on the synchronised copy.
- States: IDLE, ISSUE, WAIT_FIN, WAIT_REL, WR_WAIT, DONE.
- IDLE: i_start goes to ISSUE (read, idx=0). i_wr_req goes to ISSUE (write). If both fire in the same cycle, i_start wins and i_wr_req is dropped. Requests while busy are ignored.
- ISSUE:
  - Read: o_reg_addr = BASE_ADDR + 4*idx, truncated to 16 bits (wraps).
  - Write: o_reg_addr = i_wr_addr, o_w_data = i_wr_data, latched at acceptance.
  - Set op_mode, then enable=1 one cycle later, so op_mode is stable before enable. Clear timer, go to WAIT_FIN.
- WAIT_FIN:
  - On synced finish rise: enable=0, stop timer.
  - On a read, also: o_word = {i_rd_data, i_rd_data_2, i_rd_data_3, i_rd_data_4}; o_word_idx = idx; o_word_vld pulses one cycle.
  - Then go to WAIT_REL.
  - If timer reaches TIMEOUT_CYCLES first: enable=0, o_err=1, go to DONE; a load is aborted.
- WAIT_REL: wait for synced finish fall (controller back in IDLE). Then:
  - write: go to WR_WAIT;
  - read with idx = N_WORDS-1: go to DONE;
  - otherwise idx+1 and go to ISSUE.
- WR_WAIT: count WR_WAIT_CYCLES, then go to DONE.
- DONE: o_done pulses one cycle, go to IDLE.
- o_busy = (state != IDLE), registered.
- op_mode holds its value until the next ISSUE.
- Reset mid-operation: immediate return to reset values. enable drops asynchronously; the controller is reset by the same i_rst_n.

Optional Feature:
- Macro: EEPROM_LOADER_CHKSUM_EN.
- Defined:
  - The last loaded word (idx N_WORDS-1) is a checksum: the 32-bit modulo sum of words 0..N_WORDS-2.
  - Adds output o_chk_err (1 bit, reset 0), set at DONE of a completed load if the sum mismatches; cleared on next i_start.
  - The checksum word is still strobed on o_word_vld.
- Undefined: no o_chk_err port, no adder logic.

Test Plan:
- Load, N_WORDS=4, BASE_ADDR=16'h0010, EEPROM model holds 11223344/55667788/99AABBCC/DDEEFF00 -> reg addrs 0010, 0014, 0018, 001C issued; four o_word_vld strobes with idx 0..3 and those words; single o_done; o_err=0.
- i_wr_req addr 16'h0100 data 32'hCAFEBABE -> op_mode=0, enable high until finish rise; then o_busy held for WR_WAIT_CYCLES (shortened to 1000 in sim); o_done after; EEPROM model holds CAFEBABE at 0100..0103.
- Controller model never raises finish, TIMEOUT_CYCLES=500 -> enable drops at cycle 500; o_err=1; o_done pulse; no o_word_vld.
- i_start and i_wr_req in same cycle, then i_start again while busy -> only one load runs; no write issued; no restart.
- Assert i_rst_n=0 during word 2 of a load -> o_ctrl[0], o_busy, o_word_vld go 0 immediately; after release, i_start reloads from idx 0.
- With EEPROM_LOADER_CHKSUM_EN, words 1,2,3,6 -> o_chk_err=0. Last word 7 -> o_chk_err=1 at o_done.

Source files
------------

// File: rtl/eeprom_param_loader.sv
//==============================================================================
// Module : eeprom_param_loader
// Brief  : Sequences an I2C EEPROM controller to bulk-load N_WORDS 32-bit
//          parameters and to write single words with the post-write wait.
//          Optional checksum check: define EEPROM_LOADER_CHKSUM_EN.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module eeprom_param_loader #(
    parameter logic [6:0]  DEV_ADDR       = 7'h50,
    parameter logic [15:0] BASE_ADDR      = 16'h0000,
    parameter int          N_WORDS        = 16,
    parameter logic [2:0]  CLK_RATE       = 3'd7,
    parameter int          TIMEOUT_CYCLES = 200000,
    parameter int          WR_WAIT_CYCLES = 500000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic        i_wr_req,
    input  logic [15:0] i_wr_addr,
    input  logic [31:0] i_wr_data,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err,
    output logic [31:0] o_word,
    output logic [7:0]  o_word_idx,
    output logic        o_word_vld,
    output logic [6:0]  o_dev_addr,
    output logic [15:0] o_reg_addr,
    output logic [31:0] o_w_data,
    output logic [31:0] o_ctrl,
    input  logic [31:0] i_status,
    input  logic [7:0]  i_rd_data,
    input  logic [7:0]  i_rd_data_2,
    input  logic [7:0]  i_rd_data_3,
    input  logic [7:0]  i_rd_data_4
`ifdef EEPROM_LOADER_CHKSUM_EN
    ,
    output logic        o_chk_err
`endif
);

    localparam int TMAX = (TIMEOUT_CYCLES > WR_WAIT_CYCLES) ? TIMEOUT_CYCLES : WR_WAIT_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] c_to_last  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] c_wr_last  = TW'(WR_WAIT_CYCLES - 1);
    localparam logic [7:0]    c_last_idx = 8'(N_WORDS - 1);
    localparam logic [2:0]    c_mode_wr  = 3'd0;
    localparam logic [2:0]    c_mode_rd  = 3'd1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_FIN,
        S_WAIT_REL,
        S_WR_WAIT,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    fin_sync_q;
    logic          is_rd_q, is_rd_d;
    logic [7:0]    idx_q, idx_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          enable_q, enable_d;
    logic [2:0]    mode_q, mode_d;
    logic [15:0]   reg_addr_q, reg_addr_d;
    logic [31:0]   w_data_q, w_data_d;
    logic [31:0]   word_q, word_d;
    logic [7:0]    word_idx_q, word_idx_d;
    logic          word_vld_q, word_vld_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
`ifdef EEPROM_LOADER_CHKSUM_EN
    logic [31:0]   sum_q, sum_d;
    logic          chk_bad_q, chk_bad_d;
    logic          chk_err_q, chk_err_d;
`endif

    logic        w_fin_rise;
    logic        w_fin_fall;
    logic [31:0] w_rd_word;
    logic        w_unused_status;

    // fin_sync_q[1] is the synchronised finish; [2] is its one-cycle-old copy.
    assign w_fin_rise      = fin_sync_q[1] & ~fin_sync_q[2];
    assign w_fin_fall      = ~fin_sync_q[1] & fin_sync_q[2];
    assign w_rd_word       = {i_rd_data, i_rd_data_2, i_rd_data_3, i_rd_data_4};
    assign w_unused_status = ^{i_status[31:2], i_status[0]};

    always_comb begin
        state_d    = state_q;
        is_rd_d    = is_rd_q;
        idx_d      = idx_q;
        timer_d    = timer_q;
        enable_d   = enable_q;
        mode_d     = mode_q;
        reg_addr_d = reg_addr_q;
        w_data_d   = w_data_q;
        word_d     = word_q;
        word_idx_d = word_idx_q;
        word_vld_d = 1'b0;
        err_d      = err_q;
`ifdef EEPROM_LOADER_CHKSUM_EN
        sum_d      = sum_q;
        chk_bad_d  = chk_bad_q;
        chk_err_d  = chk_err_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    is_rd_d    = 1'b1;
                    idx_d      = 8'd0;
                    mode_d     = c_mode_rd;
                    reg_addr_d = BASE_ADDR;
                    err_d      = 1'b0;
`ifdef EEPROM_LOADER_CHKSUM_EN
                    sum_d      = 32'd0;
                    chk_bad_d  = 1'b0;
                    chk_err_d  = 1'b0;
`endif
                    state_d    = S_ISSUE;
                end else if (i_wr_req) begin
                    is_rd_d    = 1'b0;
                    mode_d     = c_mode_wr;
                    reg_addr_d = i_wr_addr;
                    w_data_d   = i_wr_data;
                    err_d      = 1'b0;
                    state_d    = S_ISSUE;
                end
            end
            // op_mode/address were registered on entry, so enable rises a cycle after them.
            S_ISSUE: begin
                enable_d = 1'b1;
                timer_d  = '0;
                state_d  = S_WAIT_FIN;
            end
            S_WAIT_FIN: begin
                if (w_fin_rise) begin
                    enable_d = 1'b0;
                    if (is_rd_q) begin
                        word_d     = w_rd_word;
                        word_idx_d = idx_q;
                        word_vld_d = 1'b1;
`ifdef EEPROM_LOADER_CHKSUM_EN
                        if (idx_q == c_last_idx) begin
                            chk_bad_d = (w_rd_word != sum_q);
                        end else begin
                            sum_d = sum_q + w_rd_word;
                        end
`endif
                    end
                    state_d = S_WAIT_REL;
                end else if (timer_q == c_to_last) begin
                    enable_d = 1'b0;
                    err_d    = 1'b1;
                    state_d  = S_DONE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_WAIT_REL: begin
                if (w_fin_fall) begin
                    if (!is_rd_q) begin
                        timer_d = '0;
                        state_d = S_WR_WAIT;
                    end else if (idx_q == c_last_idx) begin
`ifdef EEPROM_LOADER_CHKSUM_EN
                        chk_err_d = chk_bad_q;
`endif
                        state_d = S_DONE;
                    end else begin
                        idx_d      = idx_q + 8'd1;
                        reg_addr_d = BASE_ADDR + {6'd0, idx_q + 8'd1, 2'b00};
                        state_d    = S_ISSUE;
                    end
                end
            end
            S_WR_WAIT: begin
                if (timer_q == c_wr_last) begin
                    state_d = S_DONE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d  = S_IDLE;
                enable_d = 1'b0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            fin_sync_q <= 3'b000;
            is_rd_q    <= 1'b0;
            idx_q      <= 8'd0;
            timer_q    <= '0;
            enable_q   <= 1'b0;
            mode_q     <= 3'd0;
            reg_addr_q <= 16'd0;
            w_data_q   <= 32'd0;
            word_q     <= 32'd0;
            word_idx_q <= 8'd0;
            word_vld_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef EEPROM_LOADER_CHKSUM_EN
            sum_q      <= 32'd0;
            chk_bad_q  <= 1'b0;
            chk_err_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            fin_sync_q <= {fin_sync_q[1:0], i_status[1]};
            is_rd_q    <= is_rd_d;
            idx_q      <= idx_d;
            timer_q    <= timer_d;
            enable_q   <= enable_d;
            mode_q     <= mode_d;
            reg_addr_q <= reg_addr_d;
            w_data_q   <= w_data_d;
            word_q     <= word_d;
            word_idx_q <= word_idx_d;
            word_vld_q <= word_vld_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
`ifdef EEPROM_LOADER_CHKSUM_EN
            sum_q      <= sum_d;
            chk_bad_q  <= chk_bad_d;
            chk_err_q  <= chk_err_d;
`endif
        end
    end

    assign o_busy     = busy_q;
    assign o_done     = done_q;
    assign o_err      = err_q;
    assign o_word     = word_q;
    assign o_word_idx = word_idx_q;
    assign o_word_vld = word_vld_q;
    assign o_dev_addr = DEV_ADDR;
    assign o_reg_addr = reg_addr_q;
    assign o_w_data   = w_data_q;
    assign o_ctrl     = {25'd0, CLK_RATE, mode_q, enable_q};
`ifdef EEPROM_LOADER_CHKSUM_EN
    assign o_chk_err  = chk_err_q;
`endif

endmodule

`default_nettype wire
